// File: rtl/seq_calculator_if.sv
// seq_calculator_if: instruction/result bundle for seq_calculator; master drives WEN/Start/RW/RX/RY/DataIn/Sel/Ctrl, slave drives busY/Carry/Busy/Done
interface seq_calculator_if #(
  parameter int WIDTH = 8,
  parameter int AW = 3
);
  logic WEN;
  logic Start;
  logic Sel;
  logic [AW-1:0] RW;
  logic [AW-1:0] RX;
  logic [AW-1:0] RY;
  logic [WIDTH-1:0] DataIn;
  logic [3:0] Ctrl;
  logic [WIDTH-1:0] busY;
  logic Carry;
  logic Busy;
  logic Done;
  modport master (output WEN, Start, Sel, RW, RX, RY, DataIn, Ctrl, input busY, Carry, Busy, Done);
  modport slave (input WEN, Start, Sel, RW, RX, RY, DataIn, Ctrl, output busY, Carry, Busy, Done);
endinterface

// File: rtl/seq_calculator.sv
// seq_calculator: register-file ALU with shift-add MUL; ports Clk, Rst (sync, active-high), bus (slave: WEN/Start/RW/RX/RY/DataIn/Sel/Ctrl in, busY/Carry/Busy/Done out)
module seq_calculator #(
  parameter int WIDTH = 8,
  parameter int AW = 3
) (
  input logic Clk,
  input logic Rst,
  seq_calculator_if.slave bus
);
  localparam int N = 1 << AW;
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR = 4'b0011, XOR = 4'b0100;
  localparam logic [3:0] NOT = 4'b0101, SLT = 4'b0110, SLL = 4'b0111, SRL = 4'b1000, SRA = 4'b1001, MUL = 4'b1010;
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_regs [N];
  logic [WIDTH-1:0] w_x, w_y, w_res, r_mplr;
  logic [SW-1:0] w_s, r_cnt;
  logic [WIDTH:0] w_sum;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nxt;
  logic [AW-1:0] r_rw, w_rw_hi;
  logic r_done, w_busy, w_launch, w_last, w_wr, w_wb, w_carry;
  assign w_x = bus.Sel ? r_regs[bus.RX] : bus.DataIn;
  assign w_y = r_regs[bus.RY];
  assign w_s = w_x[SW-1:0];
  assign w_sum = {1'b0, w_x} + {1'b0, w_y};
  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_rw_hi = r_rw + 1'b1;
  assign w_last = r_cnt == LAST;
  always_comb begin
    w_res = bus.Ctrl == ADD ? w_sum[WIDTH-1:0] :
            bus.Ctrl == SUB ? w_x - w_y :
            bus.Ctrl == AND ? w_x & w_y :
            bus.Ctrl == OR  ? w_x | w_y :
            bus.Ctrl == XOR ? w_x ^ w_y :
            bus.Ctrl == NOT ? ~w_x :
            bus.Ctrl == SLT ? WIDTH'(w_x < w_y) :
            bus.Ctrl == SLL ? w_y << w_s :
            bus.Ctrl == SRL ? w_y >> w_s :
            bus.Ctrl == SRA ? $unsigned($signed(w_y) >>> w_s) : '0;
    w_carry = bus.Ctrl == ADD ? w_sum[WIDTH] : bus.Ctrl == SUB ? w_x >= w_y : 1'b0;
  end
  always_ff @(posedge Clk) r_state <= Rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_launch ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_comb begin
    w_busy = r_state == RUN;
    w_launch = !w_busy && bus.Start && bus.Ctrl == MUL;
    w_wr = !w_busy && !w_launch && bus.WEN && bus.RW != '0;
    w_wb = w_busy && w_last;
  end
  assign bus.busY = w_res;
  assign bus.Carry = w_carry;
  assign bus.Busy = w_busy;
  assign bus.Done = r_done;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) r_regs[i] <= '0;
      r_done <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplr <= '0;
      r_rw <= '0;
    end else begin
      r_done <= w_wb;
      if (w_launch) begin
        r_acc <= '0;
        r_mcand <= {{WIDTH{1'b0}}, w_x};
        r_mplr <= w_y;
        r_rw <= bus.RW;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_acc <= w_acc_nxt;
        r_mcand <= r_mcand << 1;
        r_mplr <= r_mplr >> 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wr) r_regs[bus.RW] <= w_res;
      if (w_wb && r_rw != '0) r_regs[r_rw] <= w_acc_nxt[WIDTH-1:0];
      if (w_wb && w_rw_hi != '0) r_regs[w_rw_hi] <= w_acc_nxt[2*WIDTH-1:WIDTH];
    end
  end
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: directed-vector self-checking bench for seq_calculator (W=8, 8 registers)
module tb_seq_calculator;
  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0010, OR = 4'b0011, XOR = 4'b0100;
  localparam logic [3:0] NOT = 4'b0101, SLT = 4'b0110, SLL = 4'b0111, SRL = 4'b1000, SRA = 4'b1001, MUL = 4'b1010;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  seq_calculator_if #(.WIDTH(8), .AW(3)) bus ();
  seq_calculator #(.WIDTH(8), .AW(3)) dut (.Clk(clk), .Rst(rst), .bus(bus));
  always #50 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.WEN = 1'b0;
    bus.Start = 1'b0;
    bus.Sel = 1'b0;
    bus.DataIn = '0;
    bus.Ctrl = OR;
    bus.RW = '0;
    bus.RX = '0;
    bus.RY = '0;
  endtask
  task automatic rd(input logic [2:0] r, input logic [7:0] exp, input string tag);
    idle();
    bus.RY = r;
    #1;
    chk(tag, 32'(bus.busY), 32'(exp));
  endtask
  task automatic alu(input logic [3:0] op, input logic sel, input logic [2:0] rx, input logic [7:0] din,
                     input logic [2:0] ry, input logic [7:0] exp_y, input logic exp_c, input string tag);
    idle();
    bus.Ctrl = op;
    bus.Sel = sel;
    bus.RX = rx;
    bus.DataIn = din;
    bus.RY = ry;
    #1;
    chk({tag, ".busY"}, 32'(bus.busY), 32'(exp_y));
    chk({tag, ".Carry"}, 32'(bus.Carry), 32'(exp_c));
  endtask
  task automatic wr(input logic [2:0] r, input logic [7:0] v);
    idle();
    bus.Ctrl = ADD;
    bus.DataIn = v;
    bus.RW = r;
    bus.WEN = 1'b1;
    tick();
    idle();
  endtask
  task automatic launch(input logic sel, input logic [2:0] rx, input logic [7:0] din, input logic [2:0] ry, input logic [2:0] rw);
    idle();
    bus.Ctrl = MUL;
    bus.Start = 1'b1;
    bus.WEN = 1'b1;
    bus.Sel = sel;
    bus.RX = rx;
    bus.DataIn = din;
    bus.RY = ry;
    bus.RW = rw;
    tick();
    idle();
  endtask
  task automatic mul(input logic sel, input logic [2:0] rx, input logic [7:0] din, input logic [2:0] ry,
                     input logic [2:0] rw, input bit intrude, input string tag);
    int nb, nd, bd;
    launch(sel, rx, din, ry, rw);
    nb = int'(bus.Busy);
    nd = 0;
    bd = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      if (intrude && i == 2) begin
        bus.Ctrl = MUL;
        bus.Start = 1'b1;
        bus.WEN = 1'b1;
        bus.DataIn = 8'd99;
        bus.RW = 3'd3;
      end
      if (intrude && i == 3) begin
        bus.Ctrl = ADD;
        bus.Start = 1'b1;
        bus.WEN = 1'b1;
        bus.DataIn = 8'd99;
        bus.RW = 3'd3;
      end
      if (intrude && i == 5) rd(3'd4, 8'd156, {tag, ".live_read"});
      tick();
      nb += int'(bus.Busy);
      nd += int'(bus.Done);
      if (bus.Done) bd = int'(bus.Busy);
    end
    chk({tag, ".busy_cycles"}, 32'(nb), 32'd8);
    chk({tag, ".done_pulses"}, 32'(nd), 32'd1);
    chk({tag, ".busy_in_done"}, 32'(bd), 32'd0);
  endtask
  initial begin
    int nd;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.Busy", 32'(bus.Busy), 32'd0);
    chk("rst.Done", 32'(bus.Done), 32'd0);
    for (int r = 0; r < 8; r++) rd(3'(r), 8'd0, $sformatf("rst.R%0d", r));
    alu(ADD, 1'b0, 3'd0, 8'd200, 3'd0, 8'd200, 1'b0, "add_imm");
    wr(3'd1, 8'd200);
    rd(3'd1, 8'd200, "wr.R1");
    alu(ADD, 1'b1, 3'd1, 8'd0, 3'd1, 8'd144, 1'b1, "add_r1r1");
    alu(SUB, 1'b0, 3'd0, 8'd5, 3'd1, 8'd61, 1'b0, "sub_5_r1");
    alu(SUB, 1'b1, 3'd1, 8'd0, 3'd1, 8'd0, 1'b1, "sub_eq");
    alu(AND, 1'b0, 3'd0, 8'h0F, 3'd1, 8'h08, 1'b0, "and");
    alu(XOR, 1'b0, 3'd0, 8'hFF, 3'd1, 8'h37, 1'b0, "xor");
    alu(NOT, 1'b0, 3'd0, 8'h0F, 3'd1, 8'hF0, 1'b0, "not");
    alu(SLT, 1'b0, 3'd0, 8'd5, 3'd1, 8'd1, 1'b0, "slt_lt");
    alu(SLT, 1'b1, 3'd1, 8'd0, 3'd1, 8'd0, 1'b0, "slt_eq");
    alu(SLL, 1'b0, 3'd0, 8'd3, 3'd1, 8'h40, 1'b0, "sll");
    alu(SRL, 1'b0, 3'd0, 8'd2, 3'd1, 8'h32, 1'b0, "srl");
    alu(SRA, 1'b0, 3'd0, 8'd2, 3'd1, 8'hF2, 1'b0, "sra");
    alu(SRA, 1'b0, 3'd0, 8'h0A, 3'd1, 8'hF2, 1'b0, "sra_lowbits");
    alu(MUL, 1'b0, 3'd0, 8'd7, 3'd1, 8'd0, 1'b0, "mul_idle");
    alu(4'b1111, 1'b0, 3'd0, 8'd7, 3'd1, 8'd0, 1'b0, "undef_op");
    wr(3'd0, 8'd55);
    rd(3'd0, 8'd0, "r0_discard");
    wr(3'd1, 8'd13);
    wr(3'd2, 8'd12);
    mul(1'b1, 3'd1, 8'd0, 3'd2, 3'd4, 1'b0, "mul13x12");
    rd(3'd4, 8'd156, "mul13x12.R4");
    rd(3'd5, 8'd0, "mul13x12.R5");
    wr(3'd1, 8'd255);
    mul(1'b1, 3'd1, 8'd0, 3'd1, 3'd6, 1'b0, "mul255sq");
    rd(3'd6, 8'h01, "mul255sq.R6");
    rd(3'd7, 8'hFE, "mul255sq.R7");
    mul(1'b0, 3'd0, 8'd255, 3'd1, 3'd7, 1'b0, "mul_rw7");
    rd(3'd7, 8'h01, "mul_rw7.R7");
    rd(3'd0, 8'd0, "mul_rw7.R0");
    rd(3'd1, 8'd255, "mul_rw7.R1");
    mul(1'b0, 3'd0, 8'd10, 3'd2, 3'd4, 1'b1, "mul_intrude");
    rd(3'd4, 8'd120, "mul_intrude.R4");
    rd(3'd5, 8'd0, "mul_intrude.R5");
    rd(3'd3, 8'd0, "mul_intrude.R3");
    launch(1'b0, 3'd0, 8'd9, 3'd1, 3'd2);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.Busy", 32'(bus.Busy), 32'd0);
    nd = int'(bus.Done);
    for (int i = 0; i < 10; i++) begin
      tick();
      nd += int'(bus.Done);
    end
    chk("abort.done_pulses", 32'(nd), 32'd0);
    for (int r = 0; r < 8; r++) rd(3'(r), 8'd0, $sformatf("abort.R%0d", r));
    wr(3'd1, 8'd13);
    wr(3'd2, 8'd12);
    mul(1'b1, 3'd1, 8'd0, 3'd2, 3'd4, 1'b0, "post_abort");
    rd(3'd4, 8'd156, "post_abort.R4");
    rd(3'd5, 8'd0, "post_abort.R5");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
